// File: rtl/stack_int_unit.sv
// stack_int_unit: multi-cycle stack and interrupt sequencer for the memory stage.
// Owns the stack pointer and sequences data-memory accesses for PUSH, POP, CALL,
// RET, RTI and interrupt entry. The PC is stacked as two 16-bit words (high word
// first, so the low word sits on top); interrupt entry also stacks the CCR.
//
// Ports:
//   clk, RESET                 clock, synchronous active-high reset
//   int_req                    interrupt pulse, remembered until accepted
//   push/pop/call/ret/rti_req  level requests, held until ack
//   ack                        request accepted this cycle (combinational)
//   push_data, pc_in,          operands latched on accept
//   call_target, flags_in
//   mem_addr/wdata/we/re       data-memory port (synchronous read, 1-cycle latency)
//   mem_rdata                  data-memory read data
//   busy                       sequence in progress, stalls fetch/decode
//   pc_load, pc_target         one-cycle fetch redirect
//   flags_load, flags_out      one-cycle CCR restore (RTI)
//   pop_valid, pop_data        POP result
//   sp                         current stack pointer (next free word)
//   ovf, udf                   sticky overflow/underflow
module stack_int_unit #(
   parameter int unsigned       ADDR_W     = 11,
   parameter logic [ADDR_W-1:0] SP_INIT    = 11'h7FF,
   parameter logic [31:0]       INT_VECTOR = 32'h0000_0002
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              int_req,
   input  logic              push_req,
   input  logic              pop_req,
   input  logic              call_req,
   input  logic              ret_req,
   input  logic              rti_req,
   output logic              ack,
   input  logic [15:0]       push_data,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       call_target,
   input  logic [2:0]        flags_in,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic              busy,
   output logic              pc_load,
   output logic [31:0]       pc_target,
   output logic              flags_load,
   output logic [2:0]        flags_out,
   output logic              pop_valid,
   output logic [15:0]       pop_data,
   output logic [ADDR_W-1:0] sp,
   output logic              ovf,
   output logic              udf
);

   localparam logic [ADDR_W-1:0] SpOne = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      StIdle, StPushWr, StPopRd, StPopCap, StWrFl, StWrHi, StWrLo,
      StJump, StRdLo, StRdHi, StCapHi, StRdFl, StCapFl
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] sp_inc, sp_dec;
   logic              int_pending_q;
   logic              is_rti_q;
   logic [31:0]       pc_save_q;
   logic [2:0]        flags_save_q;
   logic [15:0]       push_data_q;
   logic [31:0]       pc_target_q;
   logic [2:0]        flags_out_q;
   logic              pop_valid_q;
   logic [15:0]       pop_data_q;
   logic              ovf_q, udf_q;
   logic              do_wr, do_rd;
   logic              g_int, g_rti, g_call;

   assign sp_inc = sp_q + SpOne;
   assign sp_dec = sp_q - SpOne;

   always_comb begin
      state_d    = state_q;
      ack        = 1'b0;
      g_int      = 1'b0;
      g_rti      = 1'b0;
      g_call     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      do_wr      = 1'b0;
      do_rd      = 1'b0;
      pc_load    = 1'b0;
      flags_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            ack = int_pending_q | rti_req | ret_req | call_req | pop_req | push_req;
            if (int_pending_q) begin
               g_int   = 1'b1;
               state_d = StWrFl;
            end else if (rti_req) begin
               g_rti   = 1'b1;
               state_d = StRdLo;
            end else if (ret_req) begin
               state_d = StRdLo;
            end else if (call_req) begin
               g_call  = 1'b1;
               state_d = StWrHi;
            end else if (pop_req) begin
               state_d = StPopRd;
            end else if (push_req) begin
               state_d = StPushWr;
            end
         end
         StPushWr: begin
            do_wr     = 1'b1;
            mem_wdata = push_data_q;
            state_d   = StIdle;
         end
         StPopRd: begin
            do_rd   = 1'b1;
            state_d = StPopCap;
         end
         StPopCap: state_d = StIdle;
         StWrFl: begin
            do_wr     = 1'b1;
            mem_wdata = {13'b0, flags_save_q};
            state_d   = StWrHi;
         end
         StWrHi: begin
            do_wr     = 1'b1;
            mem_wdata = pc_save_q[31:16];
            state_d   = StWrLo;
         end
         StWrLo: begin
            do_wr     = 1'b1;
            mem_wdata = pc_save_q[15:0];
            state_d   = StJump;
         end
         StJump: begin
            pc_load    = 1'b1;
            flags_load = is_rti_q;
            state_d    = StIdle;
         end
         StRdLo: begin
            do_rd   = 1'b1;
            state_d = StRdHi;
         end
         StRdHi: begin
            do_rd   = 1'b1;
            state_d = is_rti_q ? StRdFl : StCapHi;
         end
         StCapHi: state_d = StJump;
         StRdFl: begin
            do_rd   = 1'b1;
            state_d = StCapFl;
         end
         StCapFl: state_d = StJump;
         default: state_d = StIdle;
      endcase
      // Writes go to the free slot; reads fetch the word just above it.
      if (do_wr) begin
         mem_we   = 1'b1;
         mem_addr = sp_q;
      end else if (do_rd) begin
         mem_re   = 1'b1;
         mem_addr = sp_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q       <= StIdle;
         sp_q          <= SP_INIT;
         int_pending_q <= 1'b0;
         is_rti_q      <= 1'b0;
         pc_save_q     <= '0;
         flags_save_q  <= '0;
         push_data_q   <= '0;
         pc_target_q   <= '0;
         flags_out_q   <= '0;
         pop_valid_q   <= 1'b0;
         pop_data_q    <= '0;
         ovf_q         <= 1'b0;
         udf_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         // A new pulse in the same cycle as acceptance stays pending.
         int_pending_q <= (int_pending_q & ~g_int) | int_req;
         if (do_wr) begin
            sp_q <= sp_dec;
            if (sp_q == '0) ovf_q <= 1'b1;
         end else if (do_rd) begin
            sp_q <= sp_inc;
            if (sp_q == '1) udf_q <= 1'b1;
         end
         if (ack) begin
            pc_save_q    <= pc_in;
            flags_save_q <= flags_in;
            push_data_q  <= push_data;
            is_rti_q     <= g_rti;
         end
         if (g_int) pc_target_q <= INT_VECTOR;
         else if (g_call) pc_target_q <= call_target;
         // Return address is assembled in place as the words arrive.
         if (state_q == StRdHi) pc_target_q[15:0] <= mem_rdata;
         if (state_q == StCapHi || state_q == StRdFl) pc_target_q[31:16] <= mem_rdata;
         if (state_q == StCapFl) flags_out_q <= mem_rdata[2:0];
         if (state_q == StPopCap) pop_data_q <= mem_rdata;
         pop_valid_q <= (state_q == StPopCap);
      end
   end

   assign busy      = (state_q != StIdle);
   assign pc_target = pc_target_q;
   assign flags_out = flags_out_q;
   assign pop_valid = pop_valid_q;
   assign pop_data  = pop_data_q;
   assign sp        = sp_q;
   assign ovf       = ovf_q;
   assign udf       = udf_q;

endmodule
